// File: rtl/soc_cpu_pkg.sv
// Shared types and constants for the CPU-side memory router and its address decoder.
package soc_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_cpu_mem_router_if.sv
// CPU native memory port (valid/ready), as driven by a PicoRV32-style core.
interface soc_cpu_mem_router_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/soc_addr_dec.sv
// Combinational address-window decoder; shared with the DMA master decode.
module soc_addr_dec #(
  parameter int          NUM_TGT = 4,
  parameter logic [31:0] TGT_BASE [NUM_TGT] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000},
  parameter logic [31:0] TGT_MASK [NUM_TGT] = '{32'hF000_0000, 32'hF000_0000, 32'hE000_0000, 32'hC000_0000},
  localparam int         IW = (NUM_TGT > 32'sd1) ? $clog2(NUM_TGT) : 32'sd1
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [NUM_TGT-1:0] match_s;

  // Per-window compare.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      match_s[i] = ((addr & TGT_MASK[i]) == TGT_BASE[i]);
    end
  end

  // Walk from the top index down so the lowest overlapping window wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      hit = hit | match_s[i];
      idx = match_s[i] ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/soc_cpu_mem_router.sv
// Routes one CPU memory port to NUM_TGT targets through a registered request stage,
// with decode-miss / timeout error responses and a sticky first-error log.
module soc_cpu_mem_router
  import soc_cpu_pkg::*;
#(
  parameter int          NUM_TGT     = 4,
  parameter logic [31:0] TGT_BASE [NUM_TGT] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000},
  parameter logic [31:0] TGT_MASK [NUM_TGT] = '{32'hF000_0000, 32'hF000_0000, 32'hE000_0000, 32'hC000_0000},
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic                   clk,
  input  logic                   arst_n,
  soc_cpu_mem_router_if.slave    cpu,
  output logic [NUM_TGT-1:0]     tgt_vld,
  output logic [3:0]             tgt_we,
  output logic [29:0]            tgt_addr,
  output logic [31:0]            tgt_wdat,
  input  logic [NUM_TGT-1:0]     tgt_rdy,
  input  logic [NUM_TGT*32-1:0]  tgt_rdat,
  input  logic                   err_clr,
  output logic                   err_sticky,
  output logic [31:0]            err_addr,
  output logic [1:0]             err_code
);

  localparam int            IW      = (NUM_TGT > 32'sd1) ? $clog2(NUM_TGT) : 32'sd1;
  localparam int            CW      = (TIMEOUT_CYC > 32'sd0) ? $clog2(TIMEOUT_CYC + 32'sd1) : 32'sd1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC > 32'sd0) ? CW'(TIMEOUT_CYC - 32'sd1) : '0;
  localparam logic          TO_EN   = (TIMEOUT_CYC > 32'sd0);

  state_t             state_r, state_s;
  logic               hit_s, rdy_sel_s, timeout_s, new_err_s;
  err_code_t          new_code_s, err_code_r;
  logic [IW-1:0]      dec_idx_s, req_idx_r, vld_idx_s;
  logic [31:0]        req_addr_r, req_wdat_r, rdat_sel_s, cpu_rdata_s, cpu_rdata_r;
  logic [31:0]        err_addr_s, err_addr_r;
  logic [3:0]         req_we_r;
  logic [CW-1:0]      cnt_r;
  logic [NUM_TGT-1:0] vld_oh_s, tgt_vld_r;
  logic               cpu_ready_r, err_sticky_r;

  soc_addr_dec #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_dec (
    .addr (cpu.addr),
    .hit  (hit_s),
    .idx  (dec_idx_s)
  );

  // Pick the selected target's completion and data; other targets' rdy is ignored.
  always_comb begin
    rdy_sel_s  = 1'b0;
    rdat_sel_s = 32'h0;
    for (int i = 0; i < NUM_TGT; i++) begin
      rdy_sel_s  = (req_idx_r == IW'(i)) ? tgt_rdy[i] : rdy_sel_s;
      rdat_sel_s = (req_idx_r == IW'(i)) ? tgt_rdat[i*32 +: 32] : rdat_sel_s;
    end
  end

  // Next-state logic and error event detection.
  always_comb begin
    state_s    = state_r;
    new_err_s  = 1'b0;
    new_code_s = ERR_NONE;
    timeout_s  = TO_EN && (cnt_r == TO_LAST);
    case (state_r)
      IDLE: begin
        if (cpu.valid && hit_s) begin
          state_s = REQ;
        end else if (cpu.valid) begin
          state_s    = ERR;
          new_err_s  = 1'b1;
          new_code_s = ERR_DECODE;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (rdy_sel_s) begin
          state_s = RESP;
        end else if (timeout_s) begin
          state_s    = ERR;
          new_err_s  = 1'b1;
          new_code_s = ERR_TIMEOUT;
        end else begin
          state_s = REQ;
        end
      end
      RESP:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered outputs, derived from the state being entered.
  always_comb begin
    vld_idx_s = (state_r == IDLE) ? dec_idx_s : req_idx_r;
    vld_oh_s  = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      vld_oh_s[i] = (state_s == REQ) && (vld_idx_s == IW'(i));
    end
    if (state_s == RESP) begin
      cpu_rdata_s = (req_we_r == 4'h0) ? rdat_sel_s : 32'h0;
    end else if (state_s == ERR) begin
      cpu_rdata_s = ERR_RDATA;
    end else begin
      cpu_rdata_s = 32'h0;
    end
    err_addr_s = (state_r == IDLE) ? cpu.addr : req_addr_r;
  end

  // State register, request capture and the saturating wait counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r    <= IDLE;
      req_idx_r  <= '0;
      req_addr_r <= 32'h0;
      req_wdat_r <= 32'h0;
      req_we_r   <= 4'h0;
      cnt_r      <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && cpu.valid) begin
        req_idx_r  <= dec_idx_s;
        req_addr_r <= cpu.addr;
        req_wdat_r <= cpu.wdata;
        req_we_r   <= cpu.wstrb;
      end
      if (state_r != REQ) begin
        cnt_r <= '0;
      end else if (cnt_r != {CW{1'b1}}) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Registered handshake outputs toward CPU and targets.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tgt_vld_r   <= '0;
      cpu_ready_r <= 1'b0;
      cpu_rdata_r <= 32'h0;
    end else begin
      tgt_vld_r   <= vld_oh_s;
      cpu_ready_r <= (state_s == RESP) || (state_s == ERR);
      cpu_rdata_r <= cpu_rdata_s;
    end
  end

  // Sticky first-error capture; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_sticky_r <= 1'b0;
      err_addr_r   <= 32'h0;
      err_code_r   <= ERR_NONE;
    end else if (new_err_s && (!err_sticky_r || err_clr)) begin
      err_sticky_r <= 1'b1;
      err_addr_r   <= err_addr_s;
      err_code_r   <= new_code_s;
    end else if (err_clr) begin
      err_sticky_r <= 1'b0;
      err_addr_r   <= 32'h0;
      err_code_r   <= ERR_NONE;
    end
  end

  assign cpu.ready  = cpu_ready_r;
  assign cpu.rdata  = cpu_rdata_r;
  assign tgt_vld    = tgt_vld_r;
  assign tgt_we     = req_we_r;
  assign tgt_addr   = req_addr_r[31:2];
  assign tgt_wdat   = req_wdat_r;
  assign err_sticky = err_sticky_r;
  assign err_addr   = err_addr_r;
  assign err_code   = err_code_r;

endmodule

// File: tb/tb_soc_cpu_mem_router.sv
// Directed bench for soc_cpu_mem_router: fixed vectors with hand-computed results plus a
// short randomized back-to-back run checked against a per-transaction expectation.
module tb_soc_cpu_mem_router;

  logic        clk;
  logic        arst_n;
  logic [3:0]  tgt_vld, tgt_we, tgt_rdy;
  logic [29:0] tgt_addr;
  logic [31:0] tgt_wdat, err_addr;
  logic [127:0] tgt_rdat;
  logic        err_clr, err_sticky;
  logic [1:0]  err_code;

  soc_cpu_mem_router_if cpu_if ();

  soc_cpu_mem_router #(
    .NUM_TGT     (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .cpu        (cpu_if),
    .tgt_vld    (tgt_vld),
    .tgt_we     (tgt_we),
    .tgt_addr   (tgt_addr),
    .tgt_wdat   (tgt_wdat),
    .tgt_rdy    (tgt_rdy),
    .tgt_rdat   (tgt_rdat),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .err_addr   (err_addr),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          dly [4] = '{0, 0, 0, 0};
  int          vcnt [4] = '{0, 0, 0, 0};
  logic        never [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] rdat_val [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic        glitch_en = 1'b0;

  logic [31:0] r_rdata, r_wdat;
  int          r_lat, r_vld_cyc;
  logic [3:0]  r_vld_or, r_twe;
  logic [29:0] r_taddr;
  logic        r_oh, r_done;

  int          rt;
  logic [31:0] ra, rwd;
  logic [3:0]  rws, exp_oh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Target model: rdy on the (dly+1)-th cycle of tgt_vld; optional rdy glitches on idle targets.
  initial begin
    tgt_rdy  = 4'h0;
    tgt_rdat = 128'h0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (tgt_vld[i]) vcnt[i]++;
        else vcnt[i] = 0;
        tgt_rdy[i] = (tgt_vld[i] && !never[i] && (vcnt[i] == dly[i] + 1)) ||
                     (glitch_en && !tgt_vld[i] && ($urandom_range(0, 1) == 1));
        tgt_rdat[i*32 +: 32] = rdat_val[i];
      end
    end
  end

  // One CPU transaction starting in an IDLE cycle; returns one cycle after cpu_ready.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic clr);
    cpu_if.valid = 1'b1;
    cpu_if.addr  = addr;
    cpu_if.wdata = wdata;
    cpu_if.wstrb = wstrb;
    err_clr      = clr;
    r_lat = 0; r_vld_cyc = 0; r_vld_or = 4'h0; r_oh = 1'b1; r_done = 1'b0;
    r_rdata = 32'h0; r_taddr = 30'h0; r_twe = 4'h0; r_wdat = 32'h0;
    for (int k = 1; k <= 40 && !r_done; k++) begin
      @(posedge clk); #1;
      err_clr = 1'b0;
      r_oh = r_oh & $onehot0(tgt_vld);
      if (tgt_vld != 4'h0) begin
        r_vld_or  = r_vld_or | tgt_vld;
        r_vld_cyc = r_vld_cyc + 1;
        r_taddr   = tgt_addr;
        r_twe     = tgt_we;
        r_wdat    = tgt_wdat;
      end
      if (cpu_if.ready) begin
        r_rdata = cpu_if.rdata;
        r_lat   = k + 1;
        r_done  = 1'b1;
      end
    end
    cpu_if.valid = 1'b0;
    if (!r_done) chk("ready_bound", 32'(cpu_if.ready), 32'd1);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(cpu_if.ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; err_clr = 1'b0;
    cpu_if.valid = 1'b0; cpu_if.addr = 32'h0; cpu_if.wdata = 32'h0; cpu_if.wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",    32'(tgt_vld), 32'h0);
    chk("rst_ready",  32'(cpu_if.ready), 32'h0);
    chk("rst_rdata",  cpu_if.rdata, 32'h0);
    chk("rst_taddr",  32'(tgt_addr), 32'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    chk("rst_code",   32'(err_code), 32'h0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;

    // 1: DMEM read, rdy in first REQ cycle
    dly[1] = 0; rdat_val[1] = 32'h1234_5678;
    txn(32'h1000_0010, 32'h0, 4'h0, 1'b0);
    chk("t1_rdata", r_rdata, 32'h1234_5678);
    chk("t1_vld",   32'(r_vld_or), 32'h2);
    chk("t1_vcyc",  r_vld_cyc, 32'd1);
    chk("t1_taddr", 32'(r_taddr), 32'h0400_0004);
    chk("t1_lat",   r_lat, 32'd3);

    // 2: CSR write, rdy after 5 waits
    dly[2] = 5; rdat_val[2] = 32'h5555_AAAA;
    txn(32'h2000_0000, 32'hA5A5_5A5A, 4'b0011, 1'b0);
    chk("t2_we",     32'(r_twe), 32'h3);
    chk("t2_wdat",   r_wdat, 32'hA5A5_5A5A);
    chk("t2_vld",    32'(r_vld_or), 32'h4);
    chk("t2_vcyc",   r_vld_cyc, 32'd6);
    chk("t2_lat",    r_lat, 32'd8);
    chk("t2_rdata",  r_rdata, 32'h0);
    chk("t2_sticky", 32'(err_sticky), 32'h0);

    // 3: 0x3000_0000 still falls in the CSR window (mask E), 0x8000_0000 misses everything
    dly[2] = 0; rdat_val[2] = 32'h0BAD_F00D;
    txn(32'h3000_0000, 32'h0, 4'h0, 1'b0);
    chk("t3_csr_vld",   32'(r_vld_or), 32'h4);
    chk("t3_csr_rdata", r_rdata, 32'h0BAD_F00D);
    txn(32'h8000_0000, 32'h0, 4'h0, 1'b0);
    chk("t3_vld",   32'(r_vld_or), 32'h0);
    chk("t3_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("t3_lat",   r_lat, 32'd2);
    chk("t3_code",  32'(err_code), 32'd1);
    chk("t3_addr",  err_addr, 32'h8000_0000);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("t3_clr_sticky", 32'(err_sticky), 32'h0);

    // 4: SDRAM never ready -> timeout after 8 REQ cycles
    never[3] = 1'b1;
    txn(32'h4000_0100, 32'h0, 4'h0, 1'b0);
    chk("t4_vld",    32'(r_vld_or), 32'h8);
    chk("t4_vcyc",   r_vld_cyc, 32'd8);
    chk("t4_lat",    r_lat, 32'd10);
    chk("t4_rdata",  r_rdata, 32'hDEAD_BEEF);
    chk("t4_code",   32'(err_code), 32'd2);
    chk("t4_addr",   err_addr, 32'h4000_0100);
    chk("t4_sticky", 32'(err_sticky), 32'h1);
    txn(32'h5000_0200, 32'h1111_2222, 4'hF, 1'b0);
    chk("t4b_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("t4b_addr",  err_addr, 32'h4000_0100);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("t4_clr_sticky", 32'(err_sticky), 32'h0);
    chk("t4_clr_code",   32'(err_code), 32'h0);
    txn(32'h8000_0000, 32'h0, 4'h0, 1'b0);
    chk("t4c_code", 32'(err_code), 32'd1);
    txn(32'hC000_0006, 32'h0, 4'h0, 1'b1);
    chk("t4d_addr",   err_addr, 32'hC000_0006);
    chk("t4d_sticky", 32'(err_sticky), 32'h1);

    // 5: async reset in the middle of a REQ
    cpu_if.valid = 1'b1; cpu_if.addr = 32'h4000_0008; cpu_if.wstrb = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_pre_vld", 32'(tgt_vld), 32'h8);
    arst_n = 1'b0; #1;
    chk("t5_vld",    32'(tgt_vld), 32'h0);
    chk("t5_taddr",  32'(tgt_addr), 32'h0);
    chk("t5_ready",  32'(cpu_if.ready), 32'h0);
    chk("t5_sticky", 32'(err_sticky), 32'h0);
    chk("t5_eaddr",  err_addr, 32'h0);
    cpu_if.valid = 1'b0; never[3] = 1'b0;
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    dly[0] = 1; rdat_val[0] = 32'hCAFE_0001;
    txn(32'h0000_0040, 32'h0, 4'h0, 1'b0);
    chk("t5_rdata", r_rdata, 32'hCAFE_0001);
    chk("t5_vld2",  32'(r_vld_or), 32'h1);
    chk("t5_lat",   r_lat, 32'd4);

    // 6: random back-to-back mix with rdy glitches on idle targets
    glitch_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rt = $urandom_range(0, 4);
      case (rt)
        0:       ra = {4'h0, 28'($urandom)};
        1:       ra = {4'h1, 28'($urandom)};
        2:       ra = {3'b001, 29'($urandom)};
        3:       ra = {2'b01, 30'($urandom)};
        default: ra = {1'b1, 31'($urandom)};
      endcase
      rws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      rwd = $urandom;
      for (int i = 0; i < 4; i++) begin
        rdat_val[i] = $urandom;
        dly[i]      = $urandom_range(0, 3);
      end
      txn(ra, rwd, rws, 1'b0);
      chk("t6_onehot", 32'(r_oh), 32'h1);
      if (rt == 4) begin
        chk("t6_miss_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("t6_miss_vld",   32'(r_vld_or), 32'h0);
        chk("t6_miss_lat",   r_lat, 32'd2);
      end else begin
        exp_oh = 4'b0001 << rt;
        chk("t6_rdata", r_rdata, (rws != 4'h0) ? 32'h0 : rdat_val[rt]);
        chk("t6_vld",   32'(r_vld_or), 32'(exp_oh));
        chk("t6_taddr", 32'(r_taddr), 32'(ra[31:2]));
        chk("t6_we",    32'(r_twe), 32'(rws));
        chk("t6_wdat",  r_wdat, rwd);
        chk("t6_lat",   r_lat, 32'(dly[rt] + 3));
      end
    end
    glitch_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
